// File: rtl/debounced_event_counter.sv
// Multi-channel key debounce, edge detect and event counter; one instance serves all keys.
// Optional raw (undebounced) rising-edge counters: define DEBOUNCED_EVENT_COUNTER_RAW_CNT_EN.
module debounced_event_counter #(
    parameter int CHANNELS  = 2,
    parameter int CNT_W     = 4,
    parameter int DB_TICKS  = 1000000,
    parameter int EDGE_MODE = 0,
    parameter int SATURATE  = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       sw,
    input  logic [CHANNELS-1:0]       clr,
    output logic [CHANNELS-1:0]       db,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       max_tick,
`ifdef DEBOUNCED_EVENT_COUNTER_RAW_CNT_EN
    output logic [CHANNELS*CNT_W-1:0] raw_count,
`endif
    output logic [CHANNELS*CNT_W-1:0] count
);

    localparam int DBW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_TICKS - 1);

    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [1:0]       sync;
        logic             s;
        db_state_t        state;
        logic [DBW-1:0]   stab;
        logic             db_r;
        logic             db_d;
        logic             rise;
        logic             fall;
        logic             ev;
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync <= '0;
            end else begin
                sync <= {sync[0], sw[g]};
            end
        end

        assign s = sync[1];

        // db is registered alongside the state so it is high exactly in ONE and WAIT0.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state <= ZERO;
                stab  <= '0;
                db_r  <= 1'b0;
            end else begin
                case (state)
                    ZERO: begin
                        if (s) begin
                            state <= WAIT1;
                            stab  <= '0;
                        end
                    end
                    WAIT1: begin
                        if (!s) begin
                            state <= ZERO;
                        end else if (stab == DB_LAST) begin
                            state <= ONE;
                            db_r  <= 1'b1;
                        end else begin
                            stab <= stab + 1'b1;
                        end
                    end
                    ONE: begin
                        if (!s) begin
                            state <= WAIT0;
                            stab  <= '0;
                        end
                    end
                    WAIT0: begin
                        if (s) begin
                            state <= ONE;
                        end else if (stab == DB_LAST) begin
                            state <= ZERO;
                            db_r  <= 1'b0;
                        end else begin
                            stab <= stab + 1'b1;
                        end
                    end
                    default: begin
                        state <= ZERO;
                        db_r  <= 1'b0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                db_d <= 1'b0;
            end else begin
                db_d <= db_r;
            end
        end

        assign rise = db_r & ~db_d;
        assign fall = ~db_r & db_d;
        assign ev   = (EDGE_MODE == 0) ? rise :
                      (EDGE_MODE == 1) ? fall : (rise | fall);

        // clr wins over a simultaneous event; that event is dropped.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= '0;
            end else if (clr[g]) begin
                cnt <= '0;
            end else if (ev) begin
                if (cnt == '1) begin
                    cnt <= (SATURATE != 0) ? cnt : '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign db[g]                      = db_r;
        assign tick[g]                    = ev;
        assign count[g*CNT_W +: CNT_W]    = cnt;
        assign max_tick[g]                = (cnt == '1);

`ifdef DEBOUNCED_EVENT_COUNTER_RAW_CNT_EN
        logic             s_d;
        logic [CNT_W-1:0] raw_cnt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s_d     <= 1'b0;
                raw_cnt <= '0;
            end else begin
                s_d <= s;
                if (clr[g]) begin
                    raw_cnt <= '0;
                end else if (s & ~s_d) begin
                    if (raw_cnt == '1) begin
                        raw_cnt <= (SATURATE != 0) ? raw_cnt : '0;
                    end else begin
                        raw_cnt <= raw_cnt + 1'b1;
                    end
                end
            end
        end

        assign raw_count[g*CNT_W +: CNT_W] = raw_cnt;
`endif
    end

endmodule

// File: tb/tb_debounced_event_counter.sv
// Directed bench: dut_a (rising edge, wrap) and dut_b (both edges, saturate) share stimulus.
module tb_debounced_event_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] sw;
    logic [1:0] clr;
    logic [1:0] db_a, tick_a, max_a, db_b, tick_b, max_b;
    logic [7:0] cnt_a, cnt_b;
`ifdef DEBOUNCED_EVENT_COUNTER_RAW_CNT_EN
    logic [7:0] raw_a, raw_b;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    debounced_event_counter #(
        .CHANNELS(2), .CNT_W(4), .DB_TICKS(4), .EDGE_MODE(0), .SATURATE(0)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .sw(sw), .clr(clr),
        .db(db_a), .tick(tick_a), .max_tick(max_a),
`ifdef DEBOUNCED_EVENT_COUNTER_RAW_CNT_EN
        .raw_count(raw_a),
`endif
        .count(cnt_a)
    );

    debounced_event_counter #(
        .CHANNELS(2), .CNT_W(4), .DB_TICKS(4), .EDGE_MODE(2), .SATURATE(1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .sw(sw), .clr(clr),
        .db(db_b), .tick(tick_b), .max_tick(max_b),
`ifdef DEBOUNCED_EVENT_COUNTER_RAW_CNT_EN
        .raw_count(raw_b),
`endif
        .count(cnt_b)
    );

    typedef struct {
        logic [1:0] sw;
        logic [1:0] clr;
        int         cycles;
        logic [1:0] db;
        logic [7:0] ca;
        logic [7:0] cb;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic watch(input int n, input int ch, output int na, output int nb);
        na = 0;
        nb = 0;
        repeat (n) begin
            cyc(1);
            na += int'(tick_a[ch]);
            nb += int'(tick_b[ch]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int na, nb;
        bit found;

        vecs[0] = '{2'b01, 2'b00, 10, 2'b01, 8'h01, 8'h01};
        vecs[1] = '{2'b00, 2'b00, 10, 2'b00, 8'h01, 8'h02};
        vecs[2] = '{2'b11, 2'b00, 10, 2'b11, 8'h12, 8'h13};
        vecs[3] = '{2'b00, 2'b00, 10, 2'b00, 8'h12, 8'h24};
        vecs[4] = '{2'b10, 2'b01, 10, 2'b10, 8'h20, 8'h30};
        vecs[5] = '{2'b00, 2'b00, 10, 2'b00, 8'h20, 8'h40};
        vecs[6] = '{2'b01, 2'b00, 2,  2'b00, 8'h20, 8'h40};
        vecs[7] = '{2'b00, 2'b00, 10, 2'b00, 8'h20, 8'h40};

        // Reset state
        reset_n = 1'b0;
        sw      = 2'b00;
        clr     = 2'b00;
        #12;
        chk("rst_db_a", 32'(db_a), 0);
        chk("rst_tick_a", 32'(tick_a), 0);
        chk("rst_cnt_a", 32'(cnt_a), 0);
        chk("rst_max_a", 32'(max_a), 0);
        chk("rst_cnt_b", 32'(cnt_b), 0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(2);

        // Clean step: db rises exactly 7 edges after sw
        sw = 2'b01;
        for (int k = 1; k <= 7; k++) begin
            cyc(1);
            chk($sformatf("step_db_edge%0d", k), 32'(db_a[0]), (k == 7) ? 1 : 0);
            if (k == 7) chk("step_tick_a", 32'(tick_a[0]), 1);
        end
        cyc(1);
        chk("step_tick_one_cycle", 32'(tick_a[0]), 0);
        chk("step_cnt_a", 32'(cnt_a), 32'h01);
        chk("step_cnt_b", 32'(cnt_b), 32'h01);
        sw = 2'b00;
        watch(10, 0, na, nb);
        chk("release_ticks_a", 32'(na), 0);
        chk("release_ticks_b", 32'(nb), 1);
        chk("release_cnt_a", 32'(cnt_a), 32'h01);
        chk("release_cnt_b", 32'(cnt_b), 32'h02);
        chk("release_db_a", 32'(db_a), 0);

        // Reset asserted mid-WAIT1
        sw = 2'b01;
        cyc(4);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_db_a", 32'(db_a), 0);
        chk("midrst_cnt_a", 32'(cnt_a), 0);
        chk("midrst_cnt_b", 32'(cnt_b), 0);
        sw = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        watch(12, 0, na, nb);
        chk("postrst_ticks_a", 32'(na), 0);
        chk("postrst_ticks_b", 32'(nb), 0);
        chk("postrst_db_a", 32'(db_a), 0);

        // Table-driven vectors
        for (int v = 0; v < 8; v++) begin
            sw  = vecs[v].sw;
            clr = vecs[v].clr;
            cyc(vecs[v].cycles);
            chk($sformatf("vec%0d_db", v), 32'(db_a), 32'(vecs[v].db));
            chk($sformatf("vec%0d_cnt_a", v), 32'(cnt_a), 32'(vecs[v].ca));
            chk($sformatf("vec%0d_cnt_b", v), 32'(cnt_b), 32'(vecs[v].cb));
        end
        clr = 2'b00;

        // Bounce rejection
        clr = 2'b11;
        cyc(1);
        clr = 2'b00;
        chk("bounce_clr_a", 32'(cnt_a), 0);
        chk("bounce_clr_b", 32'(cnt_b), 0);
        na = 0;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            sw[0] = ((i / 2) % 2 == 0);
            cyc(1);
            na += int'(tick_a[0]);
            nb += int'(tick_b[0]);
        end
        chk("bounce_db_low", 32'(db_a[0]), 0);
        sw = 2'b01;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            na += int'(tick_a[0]);
            nb += int'(tick_b[0]);
        end
        chk("bounce_ticks_a", 32'(na), 1);
        chk("bounce_ticks_b", 32'(nb), 1);
        chk("bounce_cnt_a", 32'(cnt_a), 32'h01);
        chk("bounce_cnt_b", 32'(cnt_b), 32'h01);
`ifdef DEBOUNCED_EVENT_COUNTER_RAW_CNT_EN
        chk("bounce_raw_a", 32'(raw_a), 32'h06);
        chk("bounce_raw_b", 32'(raw_b), 32'h06);
`endif
        sw = 2'b00;
        cyc(10);
        chk("bounce_rel_cnt_a", 32'(cnt_a), 32'h01);
        chk("bounce_rel_cnt_b", 32'(cnt_b), 32'h02);

        // Wrap / saturate on channel 1
        clr = 2'b10;
        cyc(1);
        clr = 2'b00;
        for (int p = 1; p <= 16; p++) begin
            sw = 2'b10;
            cyc(10);
            sw = 2'b00;
            cyc(10);
            if (p == 7) begin
                chk("p7_cnt_a", 32'(cnt_a[7:4]), 7);
                chk("p7_cnt_b", 32'(cnt_b[7:4]), 14);
                chk("p7_max_a", 32'(max_a[1]), 0);
                chk("p7_max_b", 32'(max_b[1]), 0);
            end
            if (p == 15) begin
                chk("p15_cnt_a", 32'(cnt_a[7:4]), 15);
                chk("p15_max_a", 32'(max_a[1]), 1);
                chk("p15_cnt_b", 32'(cnt_b[7:4]), 15);
                chk("p15_max_b", 32'(max_b[1]), 1);
            end
        end
        chk("p16_wrap_a", 32'(cnt_a[7:4]), 0);
        chk("p16_max_a", 32'(max_a[1]), 0);
        chk("p16_sat_b", 32'(cnt_b[7:4]), 15);
        chk("p16_ch0_a", 32'(cnt_a[3:0]), 1);
        chk("p16_ch0_b", 32'(cnt_b[3:0]), 2);
`ifdef DEBOUNCED_EVENT_COUNTER_RAW_CNT_EN
        chk("p16_raw_wrap_a", 32'(raw_a[7:4]), 0);
        chk("p16_raw_sat_b", 32'(raw_b[7:4]), 15);
`endif

        // Clear priority over a simultaneous tick
        clr = 2'b10;
        cyc(1);
        clr = 2'b00;
        for (int p = 0; p < 5; p++) begin
            sw = 2'b10;
            cyc(10);
            sw = 2'b00;
            cyc(10);
        end
        chk("pre_clr_cnt_a", 32'(cnt_a[7:4]), 5);
        chk("pre_clr_cnt_b", 32'(cnt_b[7:4]), 10);
        sw = 2'b10;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cyc(1);
            if (tick_a[1]) found = 1'b1;
        end
        chk("clr_tick_seen", 32'(found), 1);
        clr = 2'b10;
        cyc(1);
        clr = 2'b00;
        chk("clr_cnt_a", 32'(cnt_a[7:4]), 0);
        chk("clr_cnt_b", 32'(cnt_b[7:4]), 0);
        chk("clr_ch0_a", 32'(cnt_a[3:0]), 1);
        chk("clr_ch0_b", 32'(cnt_b[3:0]), 2);
`ifdef DEBOUNCED_EVENT_COUNTER_RAW_CNT_EN
        chk("clr_raw_a", 32'(raw_a[7:4]), 0);
`endif
        cyc(2);
        chk("clr_hold_a", 32'(cnt_a[7:4]), 0);
        sw = 2'b00;
        cyc(10);
        chk("clr_rel_a", 32'(cnt_a[7:4]), 0);
        chk("clr_rel_b", 32'(cnt_b[7:4]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
